// File: rtl/switch_ingress_parser.sv
// Ingress parser: frames SOF/DA/SA/LEN/PAYLOAD/PARITY/EOF, store-and-forward.
// Define SWITCH_INGRESS_DROP_BAD_EN to silently drop bad-parity packets.
module switch_ingress_parser #(
   parameter logic [7:0] SOF_BYTE = 8'h55,
   parameter logic [7:0] EOF_BYTE = 8'hAA,
   parameter int         MAX_LEN  = 32,
   parameter int         CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [7:0]       data_in,
   input  logic             sw_enable_in,
   output logic             read_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic [7:0]       pkt_da,
   output logic [7:0]       pkt_sa,
   output logic [7:0]       pkt_len,
   output logic             pkt_err,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_DA, S_SA, S_LEN, S_PAYLOAD,
      S_PARITY, S_EOFCHK, S_HUNT, S_DRAIN
   } state_t;

   state_t     state;
   logic [7:0] acc;
   logic       parity_bad;
   logic [7:0] cnt;
   logic [7:0] rd;
   logic [7:0] rd_next;
   logic       err_r;
   logic       len_bad;
   logic [7:0] buffer [MAX_LEN];

   assign rd_next = rd + 8'd1;
   assign len_bad = (data_in == 8'd0) || (data_in > 8'(MAX_LEN));
   assign pkt_err = err_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Payload memory carries no reset; only the pointers do.
   always_ff @(posedge clock) begin
      if (state == S_PAYLOAD && sw_enable_in)
         buffer[cnt[AW-1:0]] <= data_in;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         read_out   <= 1'b1;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= 8'd0;
         err_r      <= 1'b0;
         pkt_da     <= 8'd0;
         pkt_sa     <= 8'd0;
         pkt_len    <= 8'd0;
         pkt_count  <= '0;
         err_count  <= '0;
         acc        <= 8'd0;
         parity_bad <= 1'b0;
         cnt        <= 8'd0;
         rd         <= 8'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (sw_enable_in && data_in == SOF_BYTE)
                  state <= S_DA;
            end
            S_DA: begin
               if (sw_enable_in) begin
                  pkt_da <= data_in;
                  acc    <= data_in;
                  state  <= S_SA;
               end
            end
            S_SA: begin
               if (sw_enable_in) begin
                  pkt_sa <= data_in;
                  acc    <= acc ^ data_in;
                  state  <= S_LEN;
               end
            end
            S_LEN: begin
               if (sw_enable_in) begin
                  pkt_len <= data_in;
                  acc     <= acc ^ data_in;
                  cnt     <= 8'd0;
                  if (len_bad) begin
                     err_count <= sat_inc(err_count);
                     state     <= S_HUNT;
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (sw_enable_in) begin
                  acc <= acc ^ data_in;
                  cnt <= cnt + 8'd1;
                  if (cnt == pkt_len - 8'd1)
                     state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (sw_enable_in) begin
                  parity_bad <= (data_in != acc);
                  state      <= S_EOFCHK;
               end
            end
            S_EOFCHK: begin
               if (sw_enable_in) begin
                  if (data_in != EOF_BYTE) begin
                     err_count <= sat_inc(err_count);
                     state     <= S_HUNT;
                  end else begin
`ifdef SWITCH_INGRESS_DROP_BAD_EN
                     if (parity_bad) begin
                        err_count <= sat_inc(err_count);
                        state     <= S_IDLE;
                     end else begin
`else
                     begin
                        if (parity_bad) begin
                           err_count <= sat_inc(err_count);
                           err_r     <= 1'b1;
                        end else begin
                           pkt_count <= sat_inc(pkt_count);
                        end
`endif
                        state     <= S_DRAIN;
                        read_out  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= buffer[0];
                        out_last  <= (pkt_len == 8'd1);
                        rd        <= 8'd0;
`ifdef SWITCH_INGRESS_DROP_BAD_EN
                        pkt_count <= sat_inc(pkt_count);
`endif
                     end
                  end
               end
            end
            S_HUNT: begin
               if (sw_enable_in && data_in == EOF_BYTE)
                  state <= S_IDLE;
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     err_r     <= 1'b0;
                     read_out  <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     rd       <= rd_next;
                     out_data <= buffer[rd_next[AW-1:0]];
                     out_last <= (rd_next == pkt_len - 8'd1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_ingress_parser.sv
// Scoreboard bench for switch_ingress_parser: directed packets, monitor pops
// expected beats on every handshake.
module tb_switch_ingress_parser;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  data_in = 8'd0;
   logic        sw_enable_in = 1'b0;
   logic        read_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;
   logic [7:0]  pkt_da;
   logic [7:0]  pkt_sa;
   logic [7:0]  pkt_len;
   logic        pkt_err;
   logic [15:0] pkt_count;
   logic [15:0] err_count;

   switch_ingress_parser dut (
      .clock(clock), .reset_n(reset_n),
      .data_in(data_in), .sw_enable_in(sw_enable_in),
      .read_out(read_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .pkt_da(pkt_da), .pkt_sa(pkt_sa),
      .pkt_len(pkt_len), .pkt_err(pkt_err),
      .pkt_count(pkt_count), .err_count(err_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       err;
      logic [7:0] da;
      logic [7:0] sa;
      logic [7:0] len;
   } beat_t;

   beat_t sb[$];
   int errors = 0;
   int checks = 0;
   int pkt_exp = 0;
   int err_exp = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h expected none",
                     out_data);
         end else begin
            beat_t e;
            e = sb.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_last", out_last, e.last);
            check("beat_err", pkt_err, e.err);
            check("beat_da", pkt_da, e.da);
            check("beat_sa", pkt_sa, e.sa);
            check("beat_len", pkt_len, e.len);
         end
      end
   end

   task automatic send_bytes(input logic [7:0] q[$], input bit toggle);
      foreach (q[i]) begin
         @(negedge clock);
         data_in = q[i];
         sw_enable_in = 1'b1;
         @(posedge clock);
         #1 sw_enable_in = 1'b0;
         if (toggle) @(posedge clock);
      end
   endtask

   task automatic push_beats(input logic [7:0] da, input logic [7:0] sa,
                             input logic [7:0] pl[$], input logic err);
      foreach (pl[i])
         sb.push_back('{pl[i], (i == pl.size() - 1), err, da, sa,
                        8'(pl.size())});
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(read_out && !out_valid && sb.size() == 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL drain_timeout: got %0d beats left expected 0",
                  sb.size());
      end
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_pkt_count"}, pkt_count, pkt_exp);
      check({tag, "_err_count"}, err_count, err_exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] pa[$];
      logic [7:0] pb[$];
      logic [7:0] pm[$];

      pa = '{8'h10, 8'h20};
      pb = '{8'h01, 8'h02, 8'h04};

      repeat (3) @(negedge clock);
      check("rst_read_out", read_out, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_pkt_err", pkt_err, 0);
      check("rst_out_data", out_data, 0);
      check("rst_pkt_da", pkt_da, 0);
      check_counts("rst");
      reset_n = 1'b1;

      // single packet
      push_beats(8'h03, 8'h01, pa, 1'b0);
      send_bytes('{8'h55, 8'h03, 8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'hAA},
                 1'b0);
      pkt_exp++;
      wait_drain();
      check_counts("single");

      // enable toggled every other cycle
      push_beats(8'h03, 8'h01, pa, 1'b0);
      send_bytes('{8'h55, 8'h03, 8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'hAA},
                 1'b1);
      pkt_exp++;
      wait_drain();
      check_counts("toggle");

      // bad parity
`ifndef SWITCH_INGRESS_DROP_BAD_EN
      push_beats(8'h03, 8'h01, pa, 1'b1);
`endif
      send_bytes('{8'h55, 8'h03, 8'h01, 8'h02, 8'h10, 8'h20, 8'h31, 8'hAA},
                 1'b0);
      err_exp++;
`ifdef SWITCH_INGRESS_DROP_BAD_EN
      @(negedge clock);
      check("drop_read_out", read_out, 1);
      check("drop_out_valid", out_valid, 0);
`endif
      wait_drain();
      check("post_bad_pkt_err", pkt_err, 0);
      check_counts("badpar");

      // zero length, oversize length, then a good packet back-to-back
      push_beats(8'h07, 8'h02, pb, 1'b0);
      q = '{8'h55, 8'h04, 8'h05, 8'h00, 8'h11, 8'hAA,
            8'h55, 8'h04, 8'h05, 8'h21, 8'h11, 8'h22, 8'hAA,
            8'h55, 8'h07, 8'h02, 8'h03, 8'h01, 8'h02, 8'h04, 8'h01, 8'hAA};
      send_bytes(q, 1'b0);
      err_exp += 2;
      pkt_exp++;
      wait_drain();
      check_counts("lenerr");

      // maximum length payload
      pm = {};
      for (int i = 0; i < 32; i++) pm.push_back(8'(i));
      push_beats(8'h01, 8'h02, pm, 1'b0);
      q = '{8'h55, 8'h01, 8'h02, 8'h20};
      foreach (pm[i]) q.push_back(pm[i]);
      q.push_back(8'h23);
      q.push_back(8'hAA);
      send_bytes(q, 1'b0);
      pkt_exp++;
      wait_drain();
      check_counts("maxlen");

      // back-pressure during drain
      out_ready = 1'b0;
      push_beats(8'h03, 8'h01, pa, 1'b0);
      send_bytes('{8'h55, 8'h03, 8'h01, 8'h02, 8'h10, 8'h20, 8'h30, 8'hAA},
                 1'b0);
      pkt_exp++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, 8'h10);
         check("stall_read_out", read_out, 0);
      end
      out_ready = 1'b1;
      wait_drain();
      check_counts("stall");

      // reset mid-payload
      send_bytes('{8'h55, 8'h09, 8'h08, 8'h04, 8'h11, 8'h22}, 1'b0);
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      pkt_exp = 0;
      err_exp = 0;
      check("rst2_read_out", read_out, 1);
      check("rst2_out_valid", out_valid, 0);
      check("rst2_pkt_da", pkt_da, 0);
      check_counts("rst2");
      reset_n = 1'b1;
      push_beats(8'h0A, 8'h0B, '{8'h5C}, 1'b0);
      send_bytes('{8'h55, 8'h0A, 8'h0B, 8'h01, 8'h5C, 8'h5C, 8'hAA}, 1'b0);
      pkt_exp++;
      wait_drain();
      check_counts("after_rst");

      repeat (3) @(negedge clock);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
